// File: rtl/imem_loader_if.sv
// Byte-stream, ROM programming and fetch-gate signals shared by the loader and its environment.
// master is the loader side; slave is the host / ROM / fetch side.
interface imem_loader_if #(
  parameter int XLEN = 32
) ();
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic            fetch_ren;
  logic            imem_ren;
  logic            prog_en;
  logic [XLEN-1:0] prog_addr;
  logic [XLEN-1:0] prog_data;

  modport master (
    input  rx_valid, rx_data, fetch_ren,
    output rx_ready, imem_ren, prog_en, prog_addr, prog_data
  );

  modport slave (
    output rx_valid, rx_data, fetch_ren,
    input  rx_ready, imem_ren, prog_en, prog_addr, prog_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction ROM loader: takes a length-prefixed byte frame, writes little-endian
// words through the ROM programming port and stalls the core while the load is in progress.
module imem_loader #(
  parameter int              XLEN      = 32,
  parameter int              ROM_SIZE  = 8192,
  parameter logic [XLEN-1:0] BASE_ADDR = {XLEN{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  imem_loader_if.master       bus,
  output logic                core_hold,
  output logic                load_busy,
  output logic                load_done,
  output logic                load_err,
  output logic [15:0]         words_loaded
);

  localparam int unsigned ROM_WORDS = ROM_SIZE / 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e          state_q;
  logic [15:0]     len_q;
  logic [15:0]     idx_q;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     asm_q;
  logic [17:0]     drain_q;
  logic            rx_ready_q;
  logic            prog_en_q;
  logic [XLEN-1:0] prog_addr_q;
  logic [XLEN-1:0] prog_data_q;
  logic            core_hold_q;
  logic            load_done_q;
  logic            load_err_q;

  logic            rx_fire_d;
  logic [15:0]     len_full_d;
  logic [15:0]     idx_inc_d;
  logic            len_too_big_d;
  logic [XLEN-1:0] word_addr_d;

  assign rx_fire_d     = bus.rx_valid & rx_ready_q;
  assign len_full_d    = {bus.rx_data, len_q[7:0]};
  assign idx_inc_d     = idx_q + 16'd1;
  assign len_too_big_d = 32'(len_full_d) > ROM_WORDS;
  assign word_addr_d   = BASE_ADDR + (XLEN'(idx_q) << 2);

  // Load sequencer: state plus every registered output is updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 24'd0;
      drain_q     <= 18'd0;
      rx_ready_q  <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_addr_q <= {XLEN{1'b0}};
      prog_data_q <= {XLEN{1'b0}};
      core_hold_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      prog_en_q   <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q     <= S_LEN0;
            load_err_q  <= 1'b0;
            idx_q       <= 16'd0;
            byte_cnt_q  <= 2'd0;
            rx_ready_q  <= 1'b1;
            core_hold_q <= 1'b1;
          end
        end
        S_LEN0: begin
          if (rx_fire_d) begin
            len_q[7:0] <= bus.rx_data;
            state_q    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (rx_fire_d) begin
            len_q <= len_full_d;
            if (len_full_d == 16'd0) begin
              state_q     <= S_DONE;
              rx_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else if (len_too_big_d) begin
              // Oversized frame: swallow its payload so the link stays frame-aligned.
              load_err_q <= 1'b1;
              drain_q    <= {len_full_d, 2'b00};
              state_q    <= S_DRAIN;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_fire_d) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              prog_data_q <= {bus.rx_data, asm_q};
              prog_addr_q <= word_addr_d;
              prog_en_q   <= 1'b1;
              rx_ready_q  <= 1'b0;
              state_q     <= S_WRITE;
            end else begin
              asm_q <= {bus.rx_data, asm_q[23:8]};
            end
          end
        end
        S_WRITE: begin
          idx_q <= idx_inc_d;
          if (idx_inc_d == len_q) begin
            state_q     <= S_DONE;
            load_done_q <= 1'b1;
          end else begin
            state_q    <= S_DATA;
            rx_ready_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (rx_fire_d) begin
            if (drain_q == 18'd1) begin
              state_q     <= S_DONE;
              rx_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              drain_q <= drain_q - 18'd1;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          core_hold_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          rx_ready_q  <= 1'b0;
          core_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.prog_en   = prog_en_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.imem_ren  = bus.fetch_ren & ~core_hold_q;
  assign core_hold     = core_hold_q;
  assign load_busy     = core_hold_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign words_loaded  = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes are derived directly
// from the frame bytes by a small reference model.
module tb_imem_loader;
  localparam int              XLEN      = 32;
  localparam int              ROM_SIZE  = 8192;
  localparam int              ROM_WORDS = ROM_SIZE / 4;
  localparam logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        core_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_loader_if #(.XLEN(XLEN)) bus ();

  imem_loader #(.XLEN(XLEN), .ROM_SIZE(ROM_SIZE), .BASE_ADDR(BASE_ADDR)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .bus          (bus.master),
    .core_hold    (core_hold),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int consumed = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Observe ROM writes and accepted bytes on the active edge (pre-update values).
  always @(posedge clk) begin
    if (bus.prog_en) begin
      wr_addr_q.push_back(bus.prog_addr);
      wr_data_q.push_back(bus.prog_data);
    end
    if (bus.rx_valid && bus.rx_ready) consumed++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_load(input string tag);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk_eq({tag, "_hold"},  32'(core_hold), 32'd1);
    chk_eq({tag, "_busy"},  32'(load_busy), 32'd1);
    chk_eq({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
    chk_eq({tag, "_ren"},   32'(bus.imem_ren), 32'd0);
    chk_eq({tag, "_errclr"}, 32'(load_err), 32'd0);
  endtask

  // Present bytes from the current negedge on; a byte advances when valid & ready at the edge.
  task automatic send_frame(input string tag, input byte_q_t f, input bit rnd);
    int i = 0;
    int budget = 0;
    while (i < f.size() && budget < 60000) begin
      bus.rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rx_data  = f[i];
      load_start   = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (bus.rx_valid && bus.rx_ready) i++;
      @(negedge clk);
      budget++;
    end
    bus.rx_valid = 1'b0;
    load_start   = 1'b0;
    if (i != f.size()) chk_eq({tag, "_send_timeout"}, 32'(i), 32'(f.size()));
  endtask

  task automatic run_load(input string tag, input byte_q_t f, input bit rnd);
    int n;
    bit err;
    int nw;
    int lat;
    n   = int'(f[0]) | (int'(f[1]) << 8);
    err = n > ROM_WORDS;
    nw  = err ? 0 : n;
    wr_addr_q.delete();
    wr_data_q.delete();
    consumed = 0;
    start_load(tag);
    send_frame(tag, f, rnd);
    chk_eq({tag, "_lastwr"}, 32'(bus.prog_en), 32'(nw != 0));
    lat = 0;
    while (!load_done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk_eq({tag, "_donelat"}, 32'(lat), (nw != 0) ? 32'd1 : 32'd0);
    chk_eq({tag, "_donehold"}, 32'(core_hold), 32'd1);
    @(negedge clk);
    chk_eq({tag, "_donepulse"}, 32'(load_done), 32'd0);
    chk_eq({tag, "_release"}, 32'(core_hold), 32'd0);
    chk_eq({tag, "_renback"}, 32'(bus.imem_ren), 32'd1);
    chk_eq({tag, "_err"}, 32'(load_err), 32'(err));
    chk_eq({tag, "_words"}, 32'(words_loaded), 32'(nw));
    chk_eq({tag, "_consumed"}, 32'(consumed), 32'(2 + 4 * n));
    chk_eq({tag, "_wrcnt"}, 32'(wr_addr_q.size()), 32'(nw));
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      logic [31:0] d;
      d = {f[2 + 4 * k + 3], f[2 + 4 * k + 2], f[2 + 4 * k + 1], f[2 + 4 * k]};
      chk_eq({tag, "_addr"}, wr_addr_q[k], BASE_ADDR + 32'(4 * k));
      chk_eq({tag, "_data"}, wr_data_q[k], d);
    end
  endtask

  function automatic byte_q_t make_frame(input int n);
    byte_q_t f;
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  initial begin
    byte_q_t f;
    byte_q_t basic;
    byte_q_t part;
    reset        = 1'b1;
    load_start   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.fetch_ren = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_hold",  32'(core_hold), 32'd0);
    chk_eq("rst_busy",  32'(load_busy), 32'd0);
    chk_eq("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk_eq("rst_prog",  32'(bus.prog_en), 32'd0);
    chk_eq("rst_done",  32'(load_done), 32'd0);
    chk_eq("rst_err",   32'(load_err), 32'd0);
    chk_eq("rst_ren",   32'(bus.imem_ren), 32'd0);
    chk_eq("rst_addr",  bus.prog_addr, 32'd0);
    chk_eq("rst_data",  bus.prog_data, 32'd0);
    chk_eq("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    bus.fetch_ren = 1'b1;
    @(negedge clk);
    chk_eq("idle_ren",   32'(bus.imem_ren), 32'd1);
    chk_eq("idle_hold",  32'(core_hold), 32'd0);
    chk_eq("idle_ready", 32'(bus.rx_ready), 32'd0);

    basic = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("basic", basic, 1'b0);
    run_load("toggle", basic, 1'b1);

    f = {8'h00, 8'h00};
    run_load("n0", f, 1'b0);

    f = make_frame(ROM_WORDS + 1);
    run_load("oversize", f, 1'b0);
    repeat (5) @(negedge clk);
    chk_eq("err_sticky", 32'(load_err), 32'd1);
    chk_eq("err_idle_hold", 32'(core_hold), 32'd0);

    // Reset after two bytes of the first word; the partial word must never reach the ROM.
    wr_addr_q.delete();
    wr_data_q.delete();
    start_load("midrst");
    part = {8'h02, 8'h00, 8'h11, 8'h22};
    send_frame("midrst", part, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("midrst_hold",  32'(core_hold), 32'd0);
    chk_eq("midrst_ready", 32'(bus.rx_ready), 32'd0);
    chk_eq("midrst_prog",  32'(bus.prog_en), 32'd0);
    chk_eq("midrst_done",  32'(load_done), 32'd0);
    chk_eq("midrst_words", 32'(words_loaded), 32'd0);
    chk_eq("midrst_data",  bus.prog_data, 32'd0);
    chk_eq("midrst_nowr",  32'(wr_addr_q.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_load("after_rst", basic, 1'b0);

    for (int r = 0; r < 6; r++) begin
      f = make_frame(int'($urandom_range(1, 6)));
      run_load("rand", f, 1'b1);
    end

    f = make_frame(ROM_WORDS);
    run_load("full", f, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and fetch gate for the instruction ROM. It accepts a framed byte stream (valid/ready), assembles little-endian 32-bit words, and writes them through the ROM programming port (`prog_en`/`prog_addr`/`prog_data`). While a load is in progress it stalls the core by holding `core_hold` high and masking fetch reads (`imem_ren`). It sits between the host or debug byte link, the front-end fetch unit and the instruction ROM.

## Interface
- `XLEN`, 32: address and data width of the program port.
- `ROM_SIZE`, 8192: ROM size in bytes. `ROM_WORDS = ROM_SIZE/4`.
- `BASE_ADDR`, 0: byte address of the first loaded word. Must be word-aligned.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  one-cycle request to begin a load. Honoured only in IDLE.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle. A byte transfers when `rx_valid & rx_ready`.
- `fetch_ren`  in  1  fetch unit read request.
- `imem_ren`  out  1  gated read request to the ROM: `fetch_ren & ~core_hold`.
- `prog_en`  out  1  ROM write strobe. Registered.
- `prog_addr`  out  XLEN  ROM write byte address. Registered.
- `prog_data`  out  XLEN  ROM write word. Registered.
- `core_hold`  out  1  core stall. High in every state except IDLE.
- `load_busy`  out  1  same as `core_hold`.
- `load_done`  out  1  one-cycle pulse when a load finishes.
- `load_err`  out  1  sticky length error. Cleared by an accepted `load_start` or by reset.
- `words_loaded`  out  16  count of words written in the current or most recent load.

## Operation
- Frame format: byte 0 is `N[7:0]`, byte 1 is `N[15:8]`, then 4·N data bytes. In each word the first byte goes to `[7:0]` and the last byte to `[31:24]`.
- States: IDLE, LEN0, LEN1, DATA, WRITE, DRAIN, DONE.
- IDLE: `rx_ready = 0`. On `load_start`, go to LEN0 and clear `load_err`, `words_loaded`, the word index and the byte counter.
- LEN0 / LEN1: `rx_ready = 1`. Capture N low byte, then high byte. Leaving LEN1:
  - N = 0: go to DONE.
  - N > `ROM_WORDS`: set `load_err`, go to DRAIN.
  - Otherwise: go to DATA.
- DATA: `rx_ready = 1`. Shift each accepted byte into a word assembly register. The 2-bit byte counter wraps 3 → 0. On the 4th byte, load `prog_data` and `prog_addr = BASE_ADDR + 4·idx`, then go to WRITE.
- WRITE (exactly one cycle): `prog_en = 1`, `rx_ready = 0`. Increment `idx` and `words_loaded`. If the new `idx` equals N, go to DONE; else go back to DATA.
- DRAIN: `rx_ready = 1`. Accept and discard 4·N bytes using an 18-bit counter, so the stream stays frame-aligned. Then go to DONE. No ROM writes occur.
- DONE (one cycle): `load_done = 1`, `core_hold` still high. Next state is IDLE.
- `load_start` outside IDLE is ignored.
- Bytes presented with `rx_valid` while `rx_ready = 0` are not consumed. The source must hold them.
- `prog_addr` arithmetic is modulo 2^XLEN. It cannot exceed the ROM range because N ≤ `ROM_WORDS` is enforced and `BASE_ADDR` is configured in range.

## Timing
- All state updates happen on the `clk` rising edge.
- Reset: state is IDLE. `rx_ready`, `prog_en`, `core_hold`, `load_busy`, `load_done`, `load_err` and `imem_ren` are 0. `prog_addr`, `prog_data` and `words_loaded` are 0.
- Reset in mid-load: return to IDLE next cycle and drop the partial word. Words already written stay in the ROM unless the ROM is itself reset.
- `load_start` sampled in cycle t puts the block in LEN0 at t+1. `core_hold` and `rx_ready` are high from t+1, and `imem_ren` is masked from t+1.
- 4th data byte accepted in cycle t: `prog_en` is high in t+1 only, with `prog_addr`/`prog_data` valid in t+1, and `rx_ready = 0` in t+1.
- Peak throughput is one word per 5 cycles.
- Final WRITE in cycle t: `load_done` is high at t+1, `core_hold` is low at t+2, and `imem_ren` follows `fetch_ren` from t+2.
- `prog_en` is 0 in every cycle other than WRITE.

## Test plan
- Reset, then idle with `fetch_ren = 1` → `imem_ren = 1`, `core_hold = 0`, `rx_ready = 0`, all strobes 0.
- `load_start`, then bytes 02 00 | 78 56 34 12 | EF BE AD DE, with `rx_valid` held high → two `prog_en` pulses:
  - first with (addr 0x0, data 0x12345678);
  - second with (addr 0x4, data 0xDEADBEEF);
  - then `load_done` pulses, `words_loaded = 2`, `imem_ren` is masked during the load and restored 2 cycles after the final write.
- Same frame with `rx_valid` toggled randomly → identical writes, and no byte is lost or duplicated.
- Frame with N = 0 → `load_done` one cycle after LEN1, no `prog_en`, `words_loaded = 0`.
- N = `ROM_WORDS` + 1 (0x0801) followed by 8196 bytes → `load_err = 1`, zero `prog_en` pulses, all 8196 bytes consumed, `load_done` pulses, and `load_err` stays set until the next `load_start`.
- Reset asserted after 2 of 4 bytes of word 1 → IDLE next cycle with all outputs at reset values. A new full load then writes correctly from `BASE_ADDR`.
